// File: rtl/varredor_mux_8.sv
// Channel sweeper for an 8-input mux: walks sel from 0 to 7, waits TICKS settling
// cycles on each channel, then registers mux_out together with its channel index.
//
// state   | meaning
// IDLE    | waiting for iniciar; sel holds its last value
// ESTAB   | mux settling on channel sel; counter runs 0..TICKS-1
// CAPTURA | one cycle; sample mux_out at the exiting edge
// FIM     | one cycle after channel 7; restart if continuo, else go idle
module varredor_mux_8 #(
  parameter int BITS  = 4,
  parameter int TICKS = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            iniciar,
  input  logic            continuo,
  input  logic            parar,
  input  logic [BITS-1:0] mux_out,
  output logic [2:0]      sel,
  output logic [BITS-1:0] dado,
  output logic [2:0]      canal,
  output logic            dado_valido,
  output logic            ocupado,
  output logic            pronto,
  output logic [1:0]      db_estado
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ESTAB   = 2'd1,
    CAPTURA = 2'd2,
    FIM     = 2'd3
  } estado_t;

  localparam logic [7:0] CNT_FIM = 8'(TICKS - 1);

  estado_t    estado, prox;
  logic [7:0] cnt, cnt_prox;
  logic [2:0] sel_prox;
  logic       captura;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado      <= IDLE;
      cnt         <= 8'd0;
      sel         <= 3'd0;
      dado        <= '0;
      canal       <= 3'd0;
      dado_valido <= 1'b0;
    end else begin
      estado      <= prox;
      cnt         <= cnt_prox;
      sel         <= sel_prox;
      dado_valido <= captura;
      if (captura) begin
        dado  <= mux_out;
        canal <= sel;
      end
    end
  end

  always_comb begin
    prox     = estado;
    cnt_prox = cnt;
    sel_prox = sel;
    captura  = 1'b0;
    case (estado)
      IDLE: begin
        if (iniciar && !parar) begin
          prox     = ESTAB;
          sel_prox = 3'd0;
          cnt_prox = 8'd0;
        end
      end
      ESTAB: begin
        if (parar) begin
          prox     = IDLE;
          sel_prox = 3'd0;
          cnt_prox = 8'd0;
        end else if (cnt == CNT_FIM) begin
          prox = CAPTURA;
        end else begin
          cnt_prox = cnt + 8'd1;
        end
      end
      CAPTURA: begin
        if (parar) begin
          prox     = IDLE;
          sel_prox = 3'd0;
          cnt_prox = 8'd0;
        end else begin
          captura = 1'b1;
          if (sel == 3'd7) begin
            prox = FIM;
          end else begin
            prox     = ESTAB;
            sel_prox = sel + 3'd1;
            cnt_prox = 8'd0;
          end
        end
      end
      FIM: begin
        if (continuo && !parar) begin
          prox     = ESTAB;
          sel_prox = 3'd0;
          cnt_prox = 8'd0;
        end else begin
          prox = IDLE;
          // a normal finish leaves sel on channel 7; only an abort clears it
          if (parar) sel_prox = 3'd0;
        end
      end
      default: begin
        prox     = IDLE;
        sel_prox = 3'd0;
        cnt_prox = 8'd0;
      end
    endcase
  end

  assign ocupado   = (estado != IDLE);
  assign pronto    = (estado == FIM);
  assign db_estado = estado;

endmodule

// File: tb/tb_varredor_mux_8.sv
// Directed bench for varredor_mux_8: one instance with TICKS=4, one with TICKS=1,
// both fed by a mux model returning 8'hA0 + sel.
module tb_varredor_mux_8;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, iniciar, continuo, parar;
  logic [7:0] mux_a, mux_b, dado_a, dado_b;
  logic [2:0] sel_a, sel_b, canal_a, canal_b;
  logic       val_a, val_b, ocup_a, ocup_b, pr_a, pr_b;
  logic [1:0] est_a, est_b;

  assign mux_a = 8'hA0 + {5'd0, sel_a};
  assign mux_b = 8'hA0 + {5'd0, sel_b};

  varredor_mux_8 #(.BITS(8), .TICKS(4)) dut_a (
    .clock(clock), .reset(reset), .iniciar(iniciar), .continuo(continuo),
    .parar(parar), .mux_out(mux_a), .sel(sel_a), .dado(dado_a),
    .canal(canal_a), .dado_valido(val_a), .ocupado(ocup_a), .pronto(pr_a),
    .db_estado(est_a)
  );

  varredor_mux_8 #(.BITS(8), .TICKS(1)) dut_b (
    .clock(clock), .reset(reset), .iniciar(iniciar), .continuo(continuo),
    .parar(parar), .mux_out(mux_b), .sel(sel_b), .dado(dado_b),
    .canal(canal_b), .dado_valido(val_b), .ocupado(ocup_b), .pronto(pr_b),
    .db_estado(est_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic zero_a(input string tag);
    check({tag, "_sel_a"}, 32'(sel_a), 0);
    check({tag, "_dado_a"}, 32'(dado_a), 0);
    check({tag, "_canal_a"}, 32'(canal_a), 0);
    check({tag, "_val_a"}, 32'(val_a), 0);
    check({tag, "_ocup_a"}, 32'(ocup_a), 0);
    check({tag, "_pr_a"}, 32'(pr_a), 0);
    check({tag, "_est_a"}, 32'(est_a), 0);
  endtask

  task automatic zero_b(input string tag);
    check({tag, "_sel_b"}, 32'(sel_b), 0);
    check({tag, "_dado_b"}, 32'(dado_b), 0);
    check({tag, "_canal_b"}, 32'(canal_b), 0);
    check({tag, "_val_b"}, 32'(val_b), 0);
    check({tag, "_ocup_b"}, 32'(ocup_b), 0);
    check({tag, "_pr_b"}, 32'(pr_b), 0);
    check({tag, "_est_b"}, 32'(est_b), 0);
  endtask

  task automatic reset_all;
    reset = 1'b1; iniciar = 1'b0; continuo = 1'b0; parar = 1'b0;
    step;
    step;
    reset = 1'b0;
  endtask

  // iniciar is high during cycle 0; returns at the start of cycle 1
  task automatic start;
    iniciar = 1'b1;
    step;
    iniciar = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic any_val, any_pr;
    int   n;

    // reset with garbage inputs, iniciar held high
    reset = 1'b1; iniciar = 1'b1; continuo = 1'b1; parar = 1'b1;
    step; step; step;
    zero_a("rst");
    zero_b("rst");
    parar = 1'b0;
    step;
    check("rst_ini_est", 32'(est_a), 0);
    reset = 1'b0; iniciar = 1'b0; continuo = 1'b0;
    step;
    check("post_rst_est", 32'(est_a), 0);

    // single sweep, TICKS=4, with an ignored iniciar pulse at cycle 10
    reset_all;
    start;
    for (int c = 1; c <= 42; c++) begin
      iniciar = (c == 10);
      n = (c - 1) / 5;
      check($sformatf("s_ocup_c%0d", c), 32'(ocup_a), (c <= 41) ? 1 : 0);
      check($sformatf("s_pr_c%0d", c), 32'(pr_a), (c == 41) ? 1 : 0);
      check($sformatf("s_val_c%0d", c), 32'(val_a),
            (c >= 6 && c <= 41 && (c - 1) % 5 == 0) ? 1 : 0);
      check($sformatf("s_est_c%0d", c), 32'(est_a),
            (c == 42) ? 0 : (c == 41) ? 3 : ((c - 1) % 5 == 4) ? 2 : 1);
      check($sformatf("s_sel_c%0d", c), 32'(sel_a), (c >= 41) ? 7 : n);
      if (c >= 6 && c <= 41 && (c - 1) % 5 == 0) begin
        check($sformatf("s_canal_c%0d", c), 32'(canal_a), n - 1);
        check($sformatf("s_dado_c%0d", c), 32'(dado_a), 32'h9F + n);
      end
      step;
    end
    iniciar = 1'b0;

    // continuous mode
    reset_all;
    continuo = 1'b1;
    start;
    for (int c = 1; c <= 48; c++) begin
      if (c == 41) check("c_pr41", 32'(pr_a), 1);
      if (c == 42) begin
        check("c_est42", 32'(est_a), 1);
        check("c_sel42", 32'(sel_a), 0);
        check("c_ocup42", 32'(ocup_a), 1);
      end
      if (c == 43) check("c_val43", 32'(val_a), 0);
      if (c == 46) check("c_est46", 32'(est_a), 2);
      if (c == 47) begin
        check("c_val47", 32'(val_a), 1);
        check("c_canal47", 32'(canal_a), 0);
        check("c_dado47", 32'(dado_a), 32'hA0);
        check("c_sel47", 32'(sel_a), 1);
      end
      step;
    end
    continuo = 1'b0;
    parar = 1'b1;
    step;
    parar = 1'b0;
    check("c_stop_est", 32'(est_a), 0);
    check("c_stop_sel", 32'(sel_a), 0);

    // abort while settling on channel 3
    reset_all;
    start;
    any_pr = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      parar = (c == 17);
      if (c == 16) begin
        check("a_val16", 32'(val_a), 1);
        check("a_canal16", 32'(canal_a), 2);
        check("a_dado16", 32'(dado_a), 32'hA2);
      end
      if (c == 17) begin
        check("a_sel17", 32'(sel_a), 3);
        check("a_est17", 32'(est_a), 1);
      end
      any_pr = any_pr | pr_a;
      step;
    end
    parar = 1'b0;
    check("a_est18", 32'(est_a), 0);
    check("a_sel18", 32'(sel_a), 0);
    check("a_ocup18", 32'(ocup_a), 0);
    check("a_val18", 32'(val_a), 0);
    any_val = 1'b0;
    for (int i = 0; i < 45; i++) begin
      any_val = any_val | val_a;
      any_pr  = any_pr | pr_a;
      step;
    end
    check("a_no_val", 32'(any_val), 0);
    check("a_no_pr", 32'(any_pr), 0);
    check("a_canal_kept", 32'(canal_a), 2);
    check("a_dado_kept", 32'(dado_a), 32'hA2);

    // parar beats iniciar in IDLE
    iniciar = 1'b1; parar = 1'b1;
    step;
    iniciar = 1'b0; parar = 1'b0;
    check("ip_est", 32'(est_a), 0);
    check("ip_ocup", 32'(ocup_a), 0);
    step;
    check("ip_est2", 32'(est_a), 0);

    // TICKS=1 sweep
    reset_all;
    start;
    for (int c = 1; c <= 18; c++) begin
      check($sformatf("t1_val_c%0d", c), 32'(val_b),
            (c >= 3 && c <= 17 && c % 2 == 1) ? 1 : 0);
      check($sformatf("t1_pr_c%0d", c), 32'(pr_b), (c == 17) ? 1 : 0);
      check($sformatf("t1_ocup_c%0d", c), 32'(ocup_b), (c <= 17) ? 1 : 0);
      if (c >= 3 && c <= 17 && c % 2 == 1) begin
        check($sformatf("t1_canal_c%0d", c), 32'(canal_b), (c - 3) / 2);
        check($sformatf("t1_dado_c%0d", c), 32'(dado_b), 32'hA0 + (c - 3) / 2);
      end
      step;
    end

    // reset mid-sweep at cycle 8
    reset_all;
    start;
    for (int c = 1; c <= 7; c++) step;
    check("r8_canal", 32'(canal_b), 2);
    check("r8_ocup", 32'(ocup_b), 1);
    reset = 1'b1;
    step;
    reset = 1'b0;
    zero_b("r9");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
